// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Arbitrates two register-file write requesters (A, B) onto a single write
//   port. Each grant lasts one cycle. The requester that was just acked sits
//   out the next arbitration, so one requester alone gets at most one write
//   every two cycles, while two alternating requesters get one write per cycle.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   req_a/req_b         write requests, held until acked
//   addr_a/addr_b       target register addresses (ADDR_WIDTH)
//   data_a/data_b       write data (DATA_WIDTH)
//   ack_a/ack_b         one-cycle pulse: that requester's write happens now
//   we, wAddr, wData    register-file write port
//   collide             pulse: both requesters competed for the same address
//                       at the previous edge
//
// Configuration
//   REG_WR_ARB_RR_EN    defined   -> round-robin tie-break using last_grant
//                       undefined -> fixed priority, A wins every tie
module reg_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic [DATA_WIDTH-1:0] wData,
  output logic                  collide
);

  typedef enum logic [1:0] {IDLE = 2'd0, WR_A = 2'd1, WR_B = 2'd2} state_t;

  state_t                  state, state_nxt;
  logic                    elig_a, elig_b;
  logic                    grant_a, grant_b;
  logic [ADDR_WIDTH-1:0]   w_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic                    collide_q;

  // A requester being acked this cycle is excluded, so a held req is not
  // granted twice back to back.
  assign elig_a = req_a && (state != WR_A);
  assign elig_b = req_b && (state != WR_B);

`ifdef REG_WR_ARB_RR_EN
  // last_grant: 1 = B was granted last, 0 = A. Resets to B so A wins the
  // first tie.
  logic last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last_grant <= 1'b1;
    else if (grant_a) last_grant <= 1'b0;
    else if (grant_b) last_grant <= 1'b1;
  end
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (elig_a && elig_b) begin
`ifdef REG_WR_ARB_RR_EN
      grant_a = last_grant;
      grant_b = !last_grant;
`else
      grant_a = 1'b1;
`endif
    end else begin
      grant_a = elig_a;
      grant_b = elig_b;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    if (grant_a)      state_nxt = WR_A;
    else if (grant_b) state_nxt = WR_B;
  end

  // Write address/data latched at the granting edge; held while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_addr_q  <= '0;
      w_data_q  <= '0;
      collide_q <= 1'b0;
    end else begin
      collide_q <= elig_a && elig_b && (addr_a == addr_b);
      if (grant_a) begin
        w_addr_q <= addr_a;
        w_data_q <= data_a;
      end else if (grant_b) begin
        w_addr_q <= addr_b;
        w_data_q <= data_b;
      end
    end
  end

  // Output logic, decoded purely from registered state
  always_comb begin
    we      = (state != IDLE);
    ack_a   = (state == WR_A);
    ack_b   = (state == WR_B);
    wAddr   = w_addr_q;
    wData   = w_data_q;
    collide = collide_q;
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          ack_a, ack_b, we, collide;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;

  reg_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .data_a(data_a), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b),
    .we(we), .wAddr(wAddr), .wData(wData), .collide(collide)
  );

  always #5 clk = ~clk;

  // Register-file model fed by the write port
  logic [DW-1:0] rf [8];
  always @(posedge clk) if (we) rf[wAddr] <= wData;

  typedef struct {
    logic          we, aa, ab, col;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_data = '0;
  int            total = 0;
  int            bad = 0;
  string         phase = "init";
  logic [DW-1:0] tmp;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic push_idle();
    exp_t e;
    e.we = 0; e.aa = 0; e.ab = 0; e.col = 0;
    e.addr = hold_addr; e.data = hold_data;
    sb.push_back(e);
  endtask

  task automatic push_a(input logic col);
    exp_t e;
    hold_addr = addr_a; hold_data = data_a;
    e.we = 1; e.aa = 1; e.ab = 0; e.col = col;
    e.addr = hold_addr; e.data = hold_data;
    sb.push_back(e);
  endtask

  task automatic push_b(input logic col);
    exp_t e;
    hold_addr = addr_b; hold_data = data_b;
    e.we = 1; e.aa = 0; e.ab = 1; e.col = col;
    e.addr = hold_addr; e.data = hold_data;
    sb.push_back(e);
  endtask

  // One clock: the edge samples the inputs, outputs are checked mid-cycle.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s/sb_empty observed=0 expected=1", phase);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("we", {31'd0, we}, {31'd0, e.we});
      chk("ack_a", {31'd0, ack_a}, {31'd0, e.aa});
      chk("ack_b", {31'd0, ack_b}, {31'd0, e.ab});
      chk("collide", {31'd0, collide}, {31'd0, e.col});
      chk("wAddr", {29'd0, wAddr}, {29'd0, e.addr});
      chk("wData", wData, e.data);
    end
  endtask

  // Assert reset asynchronously between edges, check at once, release on
  // the next falling edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_ack_a", {31'd0, ack_a}, 32'd0);
    chk("rst_ack_b", {31'd0, ack_b}, 32'd0);
    chk("rst_collide", {31'd0, collide}, 32'd0);
    chk("rst_wAddr", {29'd0, wAddr}, 32'd0);
    chk("rst_wData", wData, 32'd0);
    hold_addr = '0; hold_data = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    phase = "reset";
    do_reset();
    @(negedge clk); reset = 1'b0;

    // Single requester A, held
    phase = "single_a";
    req_a = 1; addr_a = 3'd3; data_a = 32'hDEADBEEF;
    push_a(0); tick();
    push_idle(); tick();
    push_a(0); tick();
    req_a = 0;
    push_idle(); tick();
    push_idle(); tick();

    // Both held at different addresses: alternate every cycle
    phase = "alt";
    do_reset();
    @(negedge clk); reset = 1'b0;
    req_a = 1; addr_a = 3'd1; data_a = 32'hA1;
    req_b = 1; addr_b = 3'd2; data_b = 32'hB2;
    push_a(0); tick();
    push_b(0); tick();
    push_a(0); tick();
    push_b(0); tick();
    req_a = 0; req_b = 0;
    push_idle(); tick();

    // Same-address collision: A first, B's write lands last
    phase = "collide";
    do_reset();
    @(negedge clk); reset = 1'b0;
    req_a = 1; addr_a = 3'd5; data_a = 32'h11;
    req_b = 1; addr_b = 3'd5; data_b = 32'h22;
    push_a(1); tick();
    req_a = 0;
    push_b(0); tick();
    req_b = 0;
    push_idle(); tick();
    tmp = rf[5];
    chk("rf5", tmp, 32'h22);

    // Tie right after A was granted: round-robin favours B, fixed favours A
    phase = "tie_after_a";
    req_a = 1; addr_a = 3'd4; data_a = 32'h44;
    push_a(0); tick();
    req_a = 0;
    push_idle(); tick();
    req_a = 1; addr_a = 3'd6; data_a = 32'h66;
    req_b = 1; addr_b = 3'd7; data_b = 32'h77;
`ifdef REG_WR_ARB_RR_EN
    push_b(0); tick();
    req_b = 0;
    push_a(0); tick();
    req_a = 0;
`else
    push_a(0); tick();
    req_a = 0;
    push_b(0); tick();
    req_b = 0;
`endif
    push_idle(); tick();

    // One-edge B pulse while A is acked
    phase = "b_pulse";
    req_a = 1; addr_a = 3'd2; data_a = 32'hA2;
    push_a(0); tick();
    req_b = 1; addr_b = 3'd3; data_b = 32'hB3;
    push_b(0); tick();
    req_b = 0;
    push_a(0); tick();
    req_a = 0;
    push_idle(); tick();
    push_idle(); tick();

    // Reset mid-WR_B, then A wins the first tie
    phase = "rst_mid_wr_b";
    req_b = 1; addr_b = 3'd6; data_b = 32'hBB;
    push_b(0); tick();
    do_reset();
    req_a = 1; addr_a = 3'd1; data_a = 32'h1A;
    req_b = 1; addr_b = 3'd2; data_b = 32'h2B;
    @(negedge clk);
    chk("in_rst_we", {31'd0, we}, 32'd0);
    reset = 1'b0;
    push_a(0); tick();
    req_a = 0;
    push_b(0); tick();
    req_b = 0;
    push_idle(); tick();

    phase = "end";
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the write-data path.
REQ-002 Parameter ADDR_WIDTH, default 3, register address width (8 registers).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_a / req_b  input  1 each  write request from requester A / B; held high until acknowledged.
REQ-006 addr_a / addr_b  input  ADDR_WIDTH each  target register address; stable while the matching req is high.
REQ-007 data_a / data_b  input  DATA_WIDTH each  write data; stable while the matching req is high.
REQ-008 ack_a / ack_b  output  1 each  one-cycle pulse; the write for that requester is being performed this cycle.
REQ-009 we  output  1  register-file write enable; drives the decoder/AND write-enable path.
REQ-010 wAddr  output  ADDR_WIDTH  register-file write address.
REQ-011 wData  output  DATA_WIDTH  register-file write data.
REQ-012 collide  output  1  pulse; both requesters presented requests to the same address in the same sampled cycle.

Function
REQ-013 FSM states IDLE, WR_A, WR_B; all outputs registered from state and a latched address/data register.
REQ-014 In IDLE, WR_A, WR_B, the next state is computed from req_a/req_b sampled on the current edge, excluding any requester whose ack is high this cycle.
REQ-015 No eligible request -> IDLE; only A eligible -> WR_A; only B eligible -> WR_B.
REQ-016 Both eligible -> the requester not named by last_grant wins; last_grant updates to the winner on every grant.
REQ-017 The grant latency is one cycle: request sampled on edge N -> we, wAddr, wData, ack_x are valid during cycle N+1.
REQ-018 In WR_A: we=1, ack_a=1, wAddr/wData = values of addr_a/data_a latched at the granting edge; WR_B is symmetric.
REQ-019 In IDLE: we=0, ack_a=ack_b=0; wAddr and wData hold their last values.
REQ-020 The acked requester is ineligible on the edge ending its ack cycle, so a held req is never granted twice; alternating requesters sustain one write per cycle.
REQ-021 A single requester sustains at most one write every two cycles.
REQ-022 collide=1 in the cycle after an edge where both are eligible and addr_a==addr_b; the loser is still granted later, so its write lands last.
REQ-023 req dropped before being acked -> no grant is issued for it; no error.
REQ-024 we is never high with ack_a and ack_b both low, and ack_a and ack_b are never high together.

Reset
REQ-025 Asserting reset at any time, including mid-write, forces state IDLE, we=0, ack_a=ack_b=0, collide=0, wAddr=0, wData=0, last_grant=B (A wins the first tie).
REQ-026 A write in flight at reset is abandoned; after reset the requester must still hold req to be serviced.

Configuration
REQ-027 Macro REG_WR_ARB_RR_EN defined -> round-robin tie-break per REQ-016.
REQ-028 Macro REG_WR_ARB_RR_EN undefined -> fixed priority: A always wins ties; last_grant is not implemented and REQ-025's last_grant clause does not apply.

Verification
REQ-029 The bench SHALL cover: reset, then req_a=1, addr_a=3, data_a=0xDEADBEEF held -> next cycle we=1, wAddr=3, wData=0xDEADBEEF, ack_a=1; the following cycle we=0; the write repeats only if req_a is still high.
REQ-030 The bench SHALL cover: req_a and req_b held continuously at addrs 1 and 2 with RR_EN defined -> grants A,B,A,B on consecutive cycles, we=1 every cycle.
REQ-031 The bench SHALL cover: same stimulus with RR_EN undefined -> A wins every tie; B granted only in cycles where A is ineligible; the sequence is A,B,A,B.
REQ-032 The bench SHALL cover: both requesting addr 5, data 0x11/0x22 -> collide=1 in cycle 1; the register holds 0x22 after both acks.
REQ-033 The bench SHALL cover: reset asserted asynchronously during WR_B -> we and ack_b drop immediately, wAddr=0, wData=0; after release A wins the first tie.
REQ-034 The bench SHALL cover: req_b pulsed for exactly one sampled edge while A is in WR_A and ineligible -> B granted next cycle, ack_b=1 once.
